// File: rtl/ram_bist_ctrl.sv
// Self-test sequencer for a single-port RAM: an LFSR fill pass, then a read
// pass that replays the same sequence and compares it against ram_q.
module ram_bist_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] SEED       = 32'hACE1_2468,
  parameter int          ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam int                    DRAIN_LAST = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  state_e                state_q, state_d;
  logic [31:0]           lfsr_q, lfsr_d, lfsr_nxt;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
  logic                  done_q, done_d;
  logic [2:0]            drain_q, drain_d;

  logic                  iss_vld;
  logic [DATA_WIDTH-1:0] iss_exp;
  logic                  cmp_vld;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;

  // In READ, lfsr_q always holds the word expected at the address being driven.
  assign iss_vld = (state_q == S_READ);
  assign iss_exp = lfsr_q[DATA_WIDTH-1:0];

  generate
    if (RD_LATENCY == 0) begin : g_nolat
      assign cmp_vld  = iss_vld;
      assign cmp_exp  = iss_exp;
      assign cmp_addr = addr_q;
    end else begin : g_pipe
      logic [RD_LATENCY-1:0]                 vld_pipe;
      logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] exp_pipe;
      logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] adr_pipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe <= '0;
          exp_pipe <= '0;
          adr_pipe <= '0;
        end else begin
          vld_pipe[0] <= iss_vld;
          exp_pipe[0] <= iss_exp;
          adr_pipe[0] <= addr_q;
          for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            exp_pipe[i] <= exp_pipe[i-1];
            adr_pipe[i] <= adr_pipe[i-1];
          end
        end
      end

      assign cmp_vld  = vld_pipe[RD_LATENCY-1];
      assign cmp_exp  = exp_pipe[RD_LATENCY-1];
      assign cmp_addr = adr_pipe[RD_LATENCY-1];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    done_d   = done_q;
    drain_d  = drain_q;
    lfsr_nxt = lfsr_step(lfsr_q);

    // Four-state compare so an X/Z read-back is flagged in netlist sims.
    if (cmp_vld && (ram_q !== cmp_exp)) begin
      if (err_q != '1) err_d  = err_q + 1'b1;
      if (err_q == '0) ferr_d = cmp_addr;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          lfsr_d  = SEED;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = SEED[DATA_WIDTH-1:0];
          err_d   = '0;
          ferr_d  = '0;
          done_d  = 1'b0;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_READ;
          lfsr_d  = SEED;
          we_d    = 1'b0;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          lfsr_d = lfsr_nxt;
          data_d = lfsr_nxt[DATA_WIDTH-1:0];
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) begin
          drain_d = '0;
          if (RD_LATENCY == 0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          addr_d = addr_q + 1'b1;
          lfsr_d = lfsr_nxt;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(DRAIN_LAST)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      done_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      drain_q <= drain_d;
    end
  end

  assign ram_we         = we_q;
  assign ram_addr       = addr_q;
  assign ram_data       = data_q;
  assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done           = done_q;
  assign pass           = done_q && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Four controllers share start/rst, each against its own RAM model:
// A (lat 1, faults vary), B (1-bit counter, two faults), C (lat 2), D (lat 1 vs 2-stage RAM).
module tb_ram_bist_ctrl;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic        a_we, b_we, c_we, d_we;
  logic [9:0]  a_addr, b_addr, c_addr, d_addr;
  logic [31:0] a_data, b_data, c_data, d_data;
  logic [31:0] a_q, b_q, c_q, d_q, c_q1, d_q1;
  logic        a_busy, b_busy, c_busy, d_busy;
  logic        a_done, b_done, c_done, d_done;
  logic        a_pass, b_pass, c_pass, d_pass;
  logic [15:0] a_err, c_err, d_err;
  logic [0:0]  b_err;
  logic [9:0]  a_ferr, b_ferr, c_ferr, d_ferr;

  ram_bist_ctrl #(.RD_LATENCY(1)) u_a (.clk(clk), .rst(rst), .start(start), .ram_we(a_we),
    .ram_addr(a_addr), .ram_data(a_data), .ram_q(a_q), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .first_err_addr(a_ferr));
  ram_bist_ctrl #(.RD_LATENCY(1), .ERR_WIDTH(1)) u_b (.clk(clk), .rst(rst), .start(start),
    .ram_we(b_we), .ram_addr(b_addr), .ram_data(b_data), .ram_q(b_q), .busy(b_busy),
    .done(b_done), .pass(b_pass), .err_count(b_err), .first_err_addr(b_ferr));
  ram_bist_ctrl #(.RD_LATENCY(2)) u_c (.clk(clk), .rst(rst), .start(start), .ram_we(c_we),
    .ram_addr(c_addr), .ram_data(c_data), .ram_q(c_q), .busy(c_busy), .done(c_done),
    .pass(c_pass), .err_count(c_err), .first_err_addr(c_ferr));
  ram_bist_ctrl #(.RD_LATENCY(1)) u_d (.clk(clk), .rst(rst), .start(start), .ram_we(d_we),
    .ram_addr(d_addr), .ram_data(d_data), .ram_q(d_q), .busy(d_busy), .done(d_done),
    .pass(d_pass), .err_count(d_err), .first_err_addr(d_ferr));

  // Behavioural RAMs; faults are stuck bits applied on the read path.
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] mem_c [1024];
  logic [31:0] mem_d [1024];
  logic        fa_en = 1'b0;
  logic [9:0]  fa_addr = '0;
  int          fa_bit = 0, fb_bit0 = 0, fb_bit1 = 0;
  logic        fa_val = 1'b0, fb_val0 = 1'b0, fb_val1 = 1'b0;

  function automatic logic [31:0] stuck(input logic [31:0] w, input logic hit, input int b,
                                        input logic v);
    logic [31:0] r;
    r = w;
    if (hit) r[b] = v;
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_data;
    a_q <= stuck(mem_a[a_addr], fa_en && (a_addr == fa_addr), fa_bit, fa_val);
    if (b_we) mem_b[b_addr] <= b_data;
    b_q <= stuck(stuck(mem_b[b_addr], b_addr == 10'h020, fb_bit0, fb_val0),
                 b_addr == 10'h3FF, fb_bit1, fb_val1);
    if (c_we) mem_c[c_addr] <= c_data;
    c_q1 <= mem_c[c_addr];
    c_q  <= c_q1;
    if (d_we) mem_d[d_addr] <= d_data;
    d_q1 <= mem_d[d_addr];
    d_q  <= d_q1;
  end

  // Reference: the pattern sequence, generated straight from the LFSR rule.
  logic [31:0] pat [1024];
  int          m_d;

  int          a_done_at, b_done_at, c_done_at, d_done_at, wr_n, wr_bad;
  logic [31:0] first_word;
  logic        done_at_accept;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ctl"}, {a_we, a_busy, a_done, a_pass}, 0);
    chk({pfx, "_addr"}, a_addr, 0);
    chk({pfx, "_data"}, a_data, 0);
    chk({pfx, "_err"}, a_err, 0);
    chk({pfx, "_ferr"}, a_ferr, 0);
    chk({pfx, "_others_busy"}, {b_busy, c_busy, d_busy}, 0);
  endtask

  // Starts a test and tracks it for a fixed window; kick_at re-asserts start
  // for one cycle after that many edges to probe start-while-busy handling.
  task automatic run_bist(input int kick_at);
    a_done_at = -1; b_done_at = -1; c_done_at = -1; d_done_at = -1;
    wr_n = 0; wr_bad = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    first_word     = a_data;
    done_at_accept = a_done;
    for (int n = 0; n <= 2055; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      start = (n == kick_at);
      if (a_we) begin
        if (wr_n > 1023 || a_addr !== 10'(wr_n) || a_data !== pat[wr_n]) wr_bad++;
        wr_n++;
      end
      if (a_done && a_done_at < 0) a_done_at = n;
      if (b_done && b_done_at < 0) b_done_at = n;
      if (c_done && c_done_at < 0) c_done_at = n;
      if (d_done && d_done_at < 0) d_done_at = n;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string r, input logic [15:0] ea_err, input logic [9:0] ea_ferr);
    chk({r, "_A_first_word"}, first_word, SEED);
    chk({r, "_A_done_clr"}, done_at_accept, 0);
    chk({r, "_A_writes"}, wr_n, 1024);
    chk({r, "_A_wr_bad"}, wr_bad, 0);
    chk({r, "_A_done_at"}, a_done_at, 2049);
    chk({r, "_A_err"}, a_err, ea_err);
    chk({r, "_A_ferr"}, a_ferr, ea_ferr);
    chk({r, "_A_pass"}, a_pass, ea_err == 0);
    chk({r, "_A_hold"}, {a_done, a_busy, a_we}, 3'b100);
    chk({r, "_B_done_at"}, b_done_at, 2049);
    chk({r, "_B_err_sat"}, b_err, 1);
    chk({r, "_B_ferr"}, b_ferr, 10'h020);
    chk({r, "_B_pass"}, b_pass, 0);
    chk({r, "_C_done_at"}, c_done_at, 2050);
    chk({r, "_C_err"}, c_err, 0);
    chk({r, "_C_ferr"}, c_ferr, 0);
    chk({r, "_C_pass"}, c_pass, 1);
    chk({r, "_D_err_range"}, (int'(d_err) >= m_d) && (int'(d_err) <= m_d + 1), 1);
    chk({r, "_D_ferr"}, d_ferr <= 10'd1, 1);
    chk({r, "_D_pass"}, d_pass, 0);
  endtask

  function automatic logic exp_hit();
    return fa_en && (pat[fa_addr][fa_bit] != fa_val);
  endfunction

  initial begin
    logic [31:0] l;
    logic        h;
    l = SEED;
    for (int i = 0; i < 1024; i++) begin
      pat[i] = l;
      l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    end
    // A latency-1 checker on a 2-stage RAM sees the previous address's word.
    m_d = 0;
    for (int i = 1; i < 1024; i++) if (pat[i] != pat[i-1]) m_d++;
    fb_bit0 = $urandom_range(0, 31);
    fb_bit1 = $urandom_range(0, 31);
    fb_val0 = ~pat[10'h020][fb_bit0];
    fb_val1 = ~pat[10'h3FF][fb_bit1];

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk); rst = 1'b0;

    run_bist(-1);
    check_run("r1_clean", 0, 0);

    fa_en = 1'b1; fa_addr = 10'h155; fa_bit = 5; fa_val = 1'b0;
    h = exp_hit();
    run_bist(-1);
    check_run("r2_sa0_155", h ? 16'd1 : 16'd0, h ? 10'h155 : 10'h000);

    fa_addr = 10'($urandom_range(0, 1023));
    fa_bit  = $urandom_range(0, 31);
    fa_val  = 1'($urandom_range(0, 1));
    h = exp_hit();
    run_bist(100);
    check_run("r3_rand_kick100", h ? 16'd1 : 16'd0, h ? fa_addr : 10'h000);

    fa_addr = 10'($urandom_range(0, 1023));
    fa_bit  = $urandom_range(0, 31);
    fa_val  = 1'($urandom_range(0, 1));
    h = exp_hit();
    run_bist(2048);
    check_run("r4_kick_at_done", h ? 16'd1 : 16'd0, h ? fa_addr : 10'h000);

    fa_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk_zero("rst_mid_write");
    @(negedge clk); rst = 1'b0;

    run_bist(int'($urandom_range(1, 2047)));
    check_run("r5_after_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
